// File: rtl/fifo_drain_ctrl.sv
// Read-side master for the 32-bit synchronous FIFO: drains burst_len words on start
// and replays them on a valid/ready stream through a 2-entry skid buffer.
module fifo_drain_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [LEN_W-1:0]  burst_len_i,
   output logic              busy_o,
   output logic              done_o,
   input  logic              fifo_empty_i,
   output logic              fifo_rd_o,
   input  logic [DATA_W-1:0] fifo_data_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DATA_W-1:0] m_data_o,
   output logic [1:0]        state_o,
   output logic [1:0]        occ_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [LEN_W-1:0] LEN_ZERO = '0;
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

   logic [1:0]        state_q, state_d;
   logic [LEN_W-1:0]  rd_left_q, rd_left_d;
   logic [LEN_W-1:0]  out_left_q, out_left_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        occ_q, occ_d;
   logic [DATA_W-1:0] buf0_q, buf0_d;
   logic [DATA_W-1:0] buf1_q, buf1_d;

   logic       pop;
   logic       capture;
   logic       rd;
   logic       room;
   logic [1:0] occ_after_pop;

   // Output stream: a word transfers on every rising edge where m_valid_o and
   // m_ready_i are both high; m_data_o is held stable while valid waits on ready.
   assign pop     = (occ_q != 2'd0) && m_ready_i;
   assign capture = inflight_q;

   // Buffer slots still free once this cycle's capture and pop have settled.
   assign room = (({1'b0, occ_q} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;

   assign rd = (state_q == S_RUN) && !fifo_empty_i && (rd_left_q != LEN_ZERO) && room;

   always_comb begin
      state_d    = state_q;
      rd_left_d  = rd_left_q;
      out_left_d = out_left_q;

      if (rd) begin
         rd_left_d = rd_left_q - LEN_ONE;
      end
      if (pop && (out_left_q != LEN_ZERO)) begin
         out_left_d = out_left_q - LEN_ONE;
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (burst_len_i != LEN_ZERO) begin
                  rd_left_d  = burst_len_i;
                  out_left_d = burst_len_i;
                  state_d    = S_RUN;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (rd && (rd_left_q == LEN_ONE)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && (out_left_q == LEN_ONE)) begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      buf0_d        = buf0_q;
      buf1_d        = buf1_q;
      occ_after_pop = occ_q - {1'b0, pop};

      if (pop && (occ_q == 2'd2)) begin
         buf0_d = buf1_q;
      end
      // The returning word lands behind whatever survives this cycle's pop.
      if (capture) begin
         if (occ_after_pop == 2'd0) begin
            buf0_d = fifo_data_i;
         end else begin
            buf1_d = fifo_data_i;
         end
      end

      occ_d      = occ_after_pop + {1'b0, capture};
      inflight_d = rd;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         rd_left_q  <= '0;
         out_left_q <= '0;
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         state_q    <= state_d;
         rd_left_q  <= rd_left_d;
         out_left_q <= out_left_d;
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
      end
   end

   assign fifo_rd_o = rd;
   assign m_valid_o = (occ_q != 2'd0);
   assign m_data_o  = buf0_q;
   assign busy_o    = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done_o    = (state_q == S_DONE);
   assign state_o   = state_q;
   assign occ_o     = occ_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FIFO feeding the DUT, table of bursts,
// scoreboard of expected words, and hand-written underflow/ignore/reset sequences.
module tb_fifo_drain_ctrl;

   localparam int DW = 32;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] burst_len = '0;
   logic          busy, done, fifo_rd, m_valid;
   logic          fifo_empty = 1'b1;
   logic          m_ready = 1'b0;
   logic [DW-1:0] fifo_data = '0;
   logic [DW-1:0] m_data;
   logic [1:0]    state, occ;

   always #5 clk = ~clk;

   fifo_drain_ctrl #(.DATA_W(DW), .LEN_W(LW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .burst_len_i(burst_len),
      .busy_o(busy), .done_o(done), .fifo_empty_i(fifo_empty), .fifo_rd_o(fifo_rd),
      .fifo_data_i(fifo_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
      .m_data_o(m_data), .state_o(state), .occ_o(occ)
   );

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] fq[$];
   logic [DW-1:0] wr_q[$];

   int cyc = 0;
   int rmode = 0;
   int phase = 0;
   int rd_cnt = 0, acc_cnt = 0, done_cnt = 0, gap_cnt = 0, out_n = 0;
   int last_acc_cyc = -10;
   bit hold_v = 1'b0;
   logic [DW-1:0] hold_d = '0;

   typedef struct {
      int          len;
      int          preload;
      int          mode;
      logic [31:0] base;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural FIFO: read data appears the edge after fifo_rd is sampled.
   initial begin
      forever begin
         @(posedge clk);
         if (fifo_rd && (fq.size() > 0)) fifo_data <= fq.pop_front();
         #1;
         while (wr_q.size() > 0) fq.push_back(wr_q.pop_front());
         fifo_empty = (fq.size() == 0);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0: m_ready = 1'b1;
            1: begin
               m_ready = (phase == 0);
               phase = (phase + 1) % 3;
            end
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         out_n  = 0;
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, hold_d);
         end
         if (fifo_rd) begin
            rd_cnt++;
            out_n++;
            check("rd_not_empty", fifo_empty, 0);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got 0x%0h with no word expected", m_data);
            end else begin
               check("m_data", m_data, exp_q.pop_front());
            end
            acc_cnt++;
            out_n--;
            if (last_acc_cyc != cyc - 1) gap_cnt++;
            last_acc_cyc = cyc;
         end
         if (fifo_rd) check("outstanding_le2", (out_n <= 2), 1);
         if (done) done_cnt++;
         hold_v = m_valid && !m_ready;
         hold_d = m_data;
      end
   end

   task automatic fifo_push(input logic [DW-1:0] w, input bit to_exp);
      wr_q.push_back(w);
      if (to_exp) exp_q.push_back(w);
      else model_q.push_back(w);
   endtask

   task automatic do_start(input int len);
      @(posedge clk);
      #1;
      start = 1'b1;
      burst_len = LW'(len);
      @(posedge clk);
      #1;
      start = 1'b0;
      burst_len = '0;
   endtask

   task automatic wait_done(output int n, output bit seen);
      n = 0;
      seen = 1'b0;
      while (!seen && (n < 3000)) begin
         @(negedge clk);
         n++;
         seen = done;
      end
      check("done_seen", seen, 1);
   endtask

   task automatic run_burst(input int len, input int mode);
      int rd0, acc0, gap0, done0, n;
      bit seen, tput;
      rmode = mode;
      tput = (mode == 0) && (len > 0) && (model_q.size() >= len);
      for (int i = 0; i < len; i++) exp_q.push_back(model_q.pop_front());
      rd0 = rd_cnt; acc0 = acc_cnt; gap0 = gap_cnt; done0 = done_cnt;
      do_start(len);
      wait_done(n, seen);
      if (len == 0) check("len0_done_latency", n, 1);
      else if (seen) check("done_after_last_accept", last_acc_cyc, cyc - 1);
      @(negedge clk);
      #1;
      check("done_one_cycle", done, 0);
      check("busy_after", busy, 0);
      check("state_idle", state, 0);
      check("reads", rd_cnt - rd0, len);
      check("accepts", acc_cnt - acc0, len);
      check("done_pulses", done_cnt - done0, 1);
      check("exp_empty", exp_q.size(), 0);
      check("fifo_left", fq.size(), model_q.size());
      if (tput) check("no_bubbles", gap_cnt - gap0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd0, acc0, done0, n;
      bit seen;

      vecs[0] = '{4,   4,   0, 32'h10};
      vecs[1] = '{4,   4,   1, 32'h10};
      vecs[2] = '{1,   1,   0, 32'hA0};
      vecs[3] = '{0,   0,   0, 32'h0};
      vecs[4] = '{8,   10,  2, 32'h100};
      vecs[5] = '{2,   0,   0, 32'h0};
      vecs[6] = '{255, 255, 2, 32'h1000};
      vecs[7] = '{3,   5,   1, 32'h50};
      vecs[8] = '{2,   0,   2, 32'h0};

      // Reset held, then released and idle.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_fifo_rd", fifo_rd, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_state", state, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_fifo_rd", fifo_rd, 0);
      check("idle_m_valid", m_valid, 0);
      check("idle_m_data", m_data, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);

      foreach (vecs[k]) begin
         for (int i = 0; i < vecs[k].preload; i++) fifo_push(vecs[k].base + 32'(16 * i), 1'b0);
         repeat (2) @(posedge clk);
         run_burst(vecs[k].len, vecs[k].mode);
      end

      // Underflow guard: only two words present for a four-word burst.
      rmode = 0;
      fifo_push(32'h10, 1'b0);
      fifo_push(32'h20, 1'b0);
      repeat (2) @(posedge clk);
      while (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
      rd0 = rd_cnt; acc0 = acc_cnt; done0 = done_cnt;
      do_start(4);
      repeat (20) @(negedge clk);
      #1;
      check("uf_reads", rd_cnt - rd0, 2);
      check("uf_rd_low", fifo_rd, 0);
      check("uf_busy", busy, 1);
      check("uf_accepts", acc_cnt - acc0, 2);
      check("uf_state_run", state, 1);
      fifo_push(32'h30, 1'b1);
      fifo_push(32'h40, 1'b1);
      wait_done(n, seen);
      @(negedge clk);
      #1;
      check("uf_reads_total", rd_cnt - rd0, 4);
      check("uf_accepts_total", acc_cnt - acc0, 4);
      check("uf_done_pulses", done_cnt - done0, 1);
      check("uf_exp_empty", exp_q.size(), 0);
      check("uf_busy_after", busy, 0);

      // A start pulse during a running burst must be ignored.
      for (int i = 0; i < 6; i++) fifo_push(32'h300 + 32'(16 * i), 1'b0);
      repeat (2) @(posedge clk);
      rmode = 1;
      for (int i = 0; i < 4; i++) exp_q.push_back(model_q.pop_front());
      rd0 = rd_cnt; acc0 = acc_cnt; done0 = done_cnt;
      do_start(4);
      repeat (3) @(posedge clk);
      #1;
      check("ign_busy", busy, 1);
      start = 1'b1;
      burst_len = LW'(1);
      @(posedge clk);
      #1;
      start = 1'b0;
      burst_len = '0;
      wait_done(n, seen);
      repeat (4) @(negedge clk);
      #1;
      check("ign_reads", rd_cnt - rd0, 4);
      check("ign_accepts", acc_cnt - acc0, 4);
      check("ign_done_pulses", done_cnt - done0, 1);
      check("ign_state_idle", state, 0);
      check("ign_fifo_left", fq.size(), model_q.size());

      // Reset in the middle of a burst after two accepted words.
      for (int i = 0; i < 4; i++) fifo_push(32'h500 + 32'(16 * i), 1'b0);
      repeat (2) @(posedge clk);
      rmode = 0;
      for (int i = 0; i < 4; i++) exp_q.push_back(model_q.pop_front());
      acc0 = acc_cnt;
      do_start(4);
      n = 0;
      while (((acc_cnt - acc0) < 2) && (n < 100)) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("rst_two_accepted", acc_cnt - acc0, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_fifo_rd", fifo_rd, 0);
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_m_data", m_data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_state", state, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      exp_q.delete();
      model_q = fq;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      run_burst(2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_drain_ctrl.md
Name: fifo_drain_ctrl

Overview:
- Read-side master for the team's 32-bit synchronous FIFO (rd/empty/data_out interface).
- On a start command it drains exactly burst_len words from the FIFO.
- It presents those words on a valid/ready output stream, with backpressure and end-of-burst signalling.
- It sits between the FIFO and any downstream consumer, and never underflows the FIFO.

Parameters:
- DATA_W, 32, data word width; matches FIFO data_out.
- LEN_W, 8, width of the burst length and counters.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset (0 = reset)
- start  input  1  single-cycle burst request; sampled only in IDLE
- burst_len  input  LEN_W  words to drain; sampled with start
- busy  output  1  high in RUN and DRAIN
- done  output  1  one-cycle pulse at burst completion
- fifo_empty  input  1  FIFO empty flag
- fifo_rd  output  1  FIFO read strobe
- fifo_data  input  DATA_W  FIFO data_out; valid the cycle after fifo_rd is sampled high
- m_valid  output  1  output word valid
- m_ready  input  1  downstream accept
- m_data  output  DATA_W  output word

Behaviour:
- Reset (rst=0, async): state=IDLE; fifo_rd=0, m_valid=0, m_data=0, busy=0, done=0; all counters, the in-flight flag and the buffer are cleared. Reset mid-burst discards all buffered and in-flight words; a read issued in the same cycle as reset is lost, not replayed.
- State machine: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 with burst_len>0 latches rd_left=out_left=burst_len, then goes to RUN.
  - IDLE: start=1 with burst_len=0 goes to DONE with no FIFO reads.
  - RUN: goes to DRAIN on the edge where the last read is issued (rd_left 1->0).
  - DRAIN: goes to DONE on the edge where the last word is accepted (out_left 1->0).
  - DONE: goes to IDLE after one cycle; done=1 only in DONE.
  - start outside IDLE is ignored.
- Read issue: fifo_rd = (state==RUN) && !fifo_empty && rd_left!=0 && (occ + inflight - pop) < 2.
  - fifo_rd is combinational from registered state plus fifo_empty and m_ready.
  - Never asserted while fifo_empty=1.
- Read latency: a read sampled at edge T sets inflight. fifo_data is written into the 2-entry output buffer at edge T+1, and the word is visible on m_valid/m_data after edge T+1.
- Output buffer: 2-entry FIFO ordered by read order; occ ranges 0..2.
  - m_valid = (occ!=0); m_data = head entry.
  - pop = m_valid && m_ready; each pop decrements out_left.
  - While m_valid=1 and m_ready=0, m_data is held stable.
  - A simultaneous capture and pop in one cycle keeps occ unchanged.
- Throughput: with fifo_empty=0 and m_ready=1 held, one word per cycle after the initial latency. No bubbles between consecutive words.
- FIFO empty mid-burst: read issue stalls and resumes when fifo_empty deasserts; no word is duplicated or dropped.
- Counter arithmetic: unsigned LEN_W-bit. No wrap: rd_left and out_left never decrement below 0.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> fifo_rd=0, m_valid=0, m_data=0, busy=0, done=0. Release, idle 5 cycles -> still all 0.
- Basic burst: FIFO preloaded 0x10,0x20,0x30,0x40, m_ready=1, start with burst_len=4 -> exactly 4 fifo_rd pulses, m_data 0x10,0x20,0x30,0x40 on consecutive cycles, done pulse for 1 cycle after the last accept, busy=0 afterwards, FIFO empty.
- Backpressure: same data with m_ready toggling 1,0,0,1,... -> m_data holds while stalled, same order and count, at most 2 reads outstanding beyond accepted words (buffer never overflows).
- Underflow guard: FIFO holds 2 words, burst_len=4 -> 2 reads then fifo_rd=0 while empty, busy=1. Write 0x30,0x40 later -> burst completes with all 4 words in order, done pulse.
- Length zero and ignored start: burst_len=0 -> done one cycle after start, no fifo_rd. start pulse during RUN -> ignored, original burst count unchanged.
- Reset mid-burst: assert rst after 2 of 4 words are accepted -> all outputs 0 immediately (asynchronously), state IDLE. A new burst_len=2 then works normally on the remaining FIFO contents.
